// File: rtl/red_seq_unit.sv
// red_seq_unit: multi-cycle signed nibble-pair reduction responder.
// Accumulates one A/B nibble pair per cycle and returns a sign-extended sum.
module red_seq_unit #(
    parameter int DATA_W = 16,
    parameter int NIBS   = DATA_W / 4,
    parameter int ACC_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] S
);

    localparam int IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBS - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DATA_W-1:0]   s_q, s_d;

    logic [3:0]          nib_a;
    logic [3:0]          nib_b;
    logic [ACC_W-1:0]    sum;
    logic                accept;

    // Current nibble pair sign-extended and added to the running sum.
    always_comb begin
        nib_a = a_q[4*idx_q +: 4];
        nib_b = b_q[4*idx_q +: 4];
        sum   = acc_q
              + {{(ACC_W-4){nib_a[3]}}, nib_a}
              + {{(ACC_W-4){nib_b[3]}}, nib_b};
    end

    // Next-state and datapath control; DONE accepts a new request like IDLE.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        s_d     = s_q;
        accept  = start && (state_q != ACCUM);

        unique case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    a_d     = A;
                    b_d     = B;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ACCUM;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCUM: begin
                acc_d = sum;
                idx_d = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    s_d     = {{(DATA_W-ACC_W){sum[ACC_W-1]}}, sum};
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
        end
    end

    // Moore outputs decoded from state.
    always_comb begin
        busy = (state_q == ACCUM);
        done = (state_q == DONE);
        S    = s_q;
    end

endmodule

// File: tb/tb_red_seq_unit.sv
// tb_red_seq_unit: directed checks of red_seq_unit against a nibble model.
// Inputs change 1ns after a rising edge; outputs are sampled there too.
module tb_red_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] S;

    int checks   = 0;
    int failures = 0;

    red_seq_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .S     (S)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [15:0] a,
                                          input logic [15:0] b);
        int acc;
        logic [3:0] n;
        acc = 0;
        for (int i = 0; i < 4; i++) begin
            n = a[4*i +: 4];
            acc += (n >= 8) ? int'(n) - 16 : int'(n);
            n = b[4*i +: 4];
            acc += (n >= 8) ? int'(n) - 16 : int'(n);
        end
        return 16'(acc);
    endfunction

    // Issue one request from IDLE and check full timing and result.
    task automatic run_op(input string tag, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] exp);
        A = a; B = b; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_busy"}, 16'(busy), 16'd1);
            chk({tag, "_nodone"}, 16'(done), 16'd0);
            tick();
        end
        chk({tag, "_done"}, 16'(done), 16'd1);
        chk({tag, "_dbusy"}, 16'(busy), 16'd0);
        chk({tag, "_S"}, S, exp);
    endtask

    initial begin
        int dcnt;
        logic [15:0] ra, rb, re;

        rst = 1'b1; start = 1'b0; A = '0; B = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rst_S", S, 16'h0000);
            chk("rst_busy", 16'(busy), 16'd0);
            chk("rst_done", 16'(done), 16'd0);
            tick();
        end

        run_op("neg", 16'h8888, 16'h8888, 16'hFFC0);
        tick();
        chk("neg_pulse", 16'(done), 16'd0);

        run_op("zero", 16'h9999, 16'h7777, 16'h0000);
        A = 16'h7777; B = 16'h7777; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i < 5; i++) begin
            chk("b2b_busy", 16'(busy), 16'd1);
            chk("b2b_nodone", 16'(done), 16'd0);
            tick();
        end
        chk("b2b_done5", 16'(done), 16'd1);
        chk("b2b_S", S, 16'h0038);
        tick();

        A = 16'h1234; B = 16'h0F0F; start = 1'b1;
        re = model(16'h1234, 16'h0F0F);
        tick();
        start = 1'b0;
        A = 16'hAAAA; B = 16'h5555;
        tick();
        start = 1'b1; A = 16'h7777; B = 16'h8000;
        tick();
        start = 1'b0; A = 16'h0001; B = 16'hFFFF;
        tick();
        A = 16'hC3C3; B = 16'h3C3C;
        chk("ign_busy", 16'(busy), 16'd1);
        tick();
        chk("ign_done", 16'(done), 16'd1);
        chk("ign_S", S, re);
        chk("ign_S8", S, 16'h0008);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done) dcnt++;
        end
        chk("ign_single", 16'(dcnt), 16'd0);

        for (int n = 0; n < 1000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            re = model(ra, rb);
            A = ra; B = rb; start = 1'b1;
            tick();
            start = 1'b0;
            A = 16'($urandom); B = 16'($urandom);
            tick();
            tick();
            tick();
            tick();
            chk("rnd_done", 16'(done), 16'd1);
            chk("rnd_S", S, re);
            tick();
        end

        A = 16'h7777; B = 16'h7777; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 16'(busy), 16'd0);
        chk("abort_S", S, 16'h0000);
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) dcnt++;
            tick();
        end
        chk("abort_quiet", 16'(dcnt), 16'd0);

        rst = 1'b1; start = 1'b1; A = 16'h7777; B = 16'h7777;
        tick();
        rst = 1'b0; start = 1'b0;
        chk("rststart_busy", 16'(busy), 16'd0);
        tick();
        chk("rststart_done", 16'(done), 16'd0);

        A = 16'h1111; B = 16'hFFFF; start = 1'b1;
        tick();
        dcnt = 0;
        for (int k = 1; k <= 20; k++) begin
            chk("cont_done", 16'(done), (k % 5 == 0) ? 16'd1 : 16'd0);
            chk("cont_busy", 16'(busy), (k % 5 == 0) ? 16'd0 : 16'd1);
            if (done) begin
                dcnt++;
                chk("cont_S", S, 16'h0000);
            end
            tick();
        end
        chk("cont_count", 16'(dcnt), 16'd4);
        start = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
